// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A start/busy/done handshake frames each operation; results hold until the next one completes.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   logic             d_bit;
   logic             br_nxt;

   // The single full-subtractor cell.
   assign d_bit  = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
   assign br_nxt = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               br_d    = bin;
               cnt_d   = '0;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            res_d  = {d_bit, res_q[WIDTH-1:1]};
            br_d   = br_nxt;
            cnt_d  = cnt_q + CW'(1);
            // Last bit: publish the completed result on the same edge.
            if (cnt_q == CW'(WIDTH - 1)) begin
               diff_d  = {d_bit, res_q[WIDTH-1:1]};
               bout_d  = br_nxt;
               ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8): directed cases, random operands
// against an integer-arithmetic reference, start-while-busy, mid-run reset, back-to-back.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         busy, done, bout, ovf;
   logic [W-1:0] diff;

   int n_vec = 0;
   int n_err = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, unsigned and signed views.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                        output logic [W-1:0] ed, output logic eb, output logic eo);
      int r, sa, sb, sr;
      r  = int'(ma) - int'(mb) - int'(mbin);
      ed = W'(r);
      eb = (r < 0);
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      sr = sa - sb - int'(mbin);
      eo = (sr > 127) || (sr < -128);
   endtask

   // Launch one operation and follow it to done. lat = edges from accept to done (-1 on timeout).
   // poke: pulse start with new operands mid-run; scramble: randomize inputs while running.
   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         input bit poke, input bit scramble,
                         output int lat, output int busy_cnt, output bit overlap,
                         output bit done_after);
      int i;
      @(negedge clk);
      a = ia; b = ib; bin = ibin; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      i = 0; busy_cnt = 0; overlap = 0; lat = -1;
      while (i < 30) begin
         if (busy && done) overlap = 1;
         if (done) begin
            lat = i;
            break;
         end
         if (busy) busy_cnt++;
         if (scramble) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
         end
         if (poke && i == 3) begin
            start = 1'b1; a = 8'hAA; b = 8'h55;
         end
         if (poke && i == 4) start = 1'b0;
         @(posedge clk);
         @(negedge clk);
         i++;
      end
      @(posedge clk);
      @(negedge clk);
      done_after = done | busy;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({busy, done, diff, bout, ovf} !== {W+4{1'b0}}) begin
         n_err++;
         $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                  busy, done, diff, bout, ovf);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_directed;
      logic [W-1:0] ta [6] = '{8'h05, 8'h00, 8'h80, 8'h7F, 8'h10, 8'h00};
      logic [W-1:0] tb [6] = '{8'h03, 8'h01, 8'h01, 8'hFF, 8'h0F, 8'h00};
      logic         tc [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
      logic [W-1:0] xd [6] = '{8'h02, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'hFF};
      logic         xb [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
      logic         xo [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
      int lat, bc;
      bit ov, da;
      for (int k = 0; k < 6; k++) begin
         run_op(ta[k], tb[k], tc[k], 0, 0, lat, bc, ov, da);
         n_vec++;
         if (lat !== W || bc !== W || ov || da) begin
            n_err++;
            $display("FAIL dir%0d_timing: got lat=%0d busy_cycles=%0d overlap=%0d lingering=%0d, want %0d/%0d/0/0",
                     k, lat, bc, ov, da, W, W);
         end
         n_vec++;
         if (diff !== xd[k] || bout !== xb[k] || ovf !== xo[k]) begin
            n_err++;
            $display("FAIL dir%0d_result: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                     k, diff, bout, ovf, xd[k], xb[k], xo[k]);
         end
      end
   endtask

   task automatic test_random;
      logic [W-1:0] ra, rb, ed;
      logic rc, eb, eo;
      int lat, bc;
      bit ov, da;
      for (int k = 0; k < 40; k++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         if (k == 0) begin ra = 8'hFF; rb = 8'hFF; rc = 1'b1; end
         if (k == 1) begin ra = 8'h80; rb = 8'h00; rc = 1'b1; end
         model(ra, rb, rc, ed, eb, eo);
         run_op(ra, rb, rc, 0, 1, lat, bc, ov, da);
         n_vec++;
         if (lat !== W || diff !== ed || bout !== eb || ovf !== eo) begin
            n_err++;
            $display("FAIL rand%0d a=%h b=%h bin=%b: got lat=%0d diff=%h bout=%b ovf=%b, want lat=%0d diff=%h bout=%b ovf=%b",
                     k, ra, rb, rc, lat, diff, bout, ovf, W, ed, eb, eo);
         end
      end
   endtask

   task automatic test_start_ignored;
      int lat, bc, extra;
      bit ov, da;
      run_op(8'h05, 8'h03, 1'b0, 1, 0, lat, bc, ov, da);
      n_vec++;
      if (lat !== W || diff !== 8'h02 || bout !== 1'b0 || ovf !== 1'b0) begin
         n_err++;
         $display("FAIL start_in_run: got lat=%0d diff=%h bout=%b ovf=%b, want lat=%0d diff=02 bout=0 ovf=0",
                  lat, diff, bout, ovf, W);
      end
      extra = 0;
      repeat (15) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      n_vec++;
      if (extra !== 0 || da) begin
         n_err++;
         $display("FAIL start_no_queue: got %0d extra busy/done cycles, want 0", extra);
      end
   endtask

   task automatic test_reset_midrun;
      int seen;
      // Leave a nonzero result behind so the clear is observable.
      @(negedge clk);
      a = 8'h00; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (W + 2) @(negedge clk);
      a = 8'h80; b = 8'h01; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_vec++;
      if ({busy, done, diff, bout, ovf} !== {W+4{1'b0}}) begin
         n_err++;
         $display("FAIL reset_midrun: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                  busy, done, diff, bout, ovf);
      end
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      n_vec++;
      if (seen !== 0) begin
         n_err++;
         $display("FAIL reset_no_done: got %0d busy/done cycles after reset, want 0", seen);
      end
   endtask

   task automatic test_back_to_back;
      int t, n_done, t0, t1, hold_bad;
      logic [W-1:0] d0, d1;
      @(negedge clk);
      a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a = 8'h00; b = 8'h01;
      t = 1; n_done = 0; t0 = -1; t1 = -1; hold_bad = 0; d0 = '0; d1 = '0;
      while (t < 40 && n_done < 2) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            if (n_done == 0) begin t0 = t; d0 = diff; end
            else begin t1 = t; d1 = diff; start = 1'b0; end
            n_done++;
         end else if (n_done == 1 && diff !== 8'h02) hold_bad++;
         t++;
      end
      start = 1'b0;
      n_vec++;
      if (t0 !== W || t1 !== W + (W + 2)) begin
         n_err++;
         $display("FAIL b2b_timing: got done at edges %0d,%0d, want %0d,%0d", t0, t1, W, 2 * W + 2);
      end
      n_vec++;
      if (d0 !== 8'h02 || d1 !== 8'hFF || hold_bad !== 0) begin
         n_err++;
         $display("FAIL b2b_results: got diff %h then %h, %0d hold violations, want 02 then ff, 0",
                  d0, d1, hold_bad);
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_reset_midrun();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b - bin` one bit per clock, LSB first, through a single registered full-subtractor cell with a borrow flip-flop. It is the inverse-operation companion to the combinational full adder in the adder library. It serves area-constrained datapaths that can trade latency for a single 1-bit arithmetic cell. A start/busy/done handshake frames each operation; results are registered and held until the next operation completes.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; captured at the accepting edge.
- `b`  in  WIDTH  subtrahend; captured at the accepting edge.
- `bin`  in  1  borrow-in; captured at the accepting edge.
- `busy`  out  1  high while bits are being processed (RUN).
- `done`  out  1  one-cycle pulse; results valid and updated.
- `diff`  out  WIDTH  difference, low WIDTH bits of a - b - bin.
- `bout`  out  1  unsigned borrow-out; 1 iff a < b + bin (unsigned).
- `ovf`  out  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - If `start` = 1 at an edge: latch `a`, `b` into shift registers, load the borrow FF with `bin`, clear the bit counter, go to RUN.
  - Otherwise stay in IDLE.
- **RUN:** each edge:
  - Compute d = a0 ^ b0 ^ br and br' = (~a0 & b0) | (~(a0 ^ b0) & br), where a0/b0 are the shift-register LSBs and br is the borrow FF.
  - Shift d into the result shift register from the MSB side; shift both operand registers right by one.
  - Update br ← br', increment the counter.
  - After the WIDTH-th bit, go to DONE.
- **Entering DONE:** the same edge that processes bit WIDTH-1 loads `diff` from the completed result register, loads `bout` from the final borrow, and computes `ovf` from the latched operand MSBs and the result MSB.
- **DONE:** lasts exactly one cycle, then goes to IDLE.
- **Output stability:** `diff`, `bout`, `ovf` change only on entry to DONE; intermediate bits are never visible on outputs.
- **`start` outside IDLE:** ignored in RUN and DONE; no queuing.
- **Input stability:** changes on `a`, `b`, `bin` after the accepting edge have no effect on the operation in flight.
- **Internal widths:**
  - Counter: $clog2(WIDTH+1) bits.
  - Borrow chain: 1 bit.
  - No saturation; the result wraps modulo 2^WIDTH.
- **Reset:** `rst_n` = 0 at any edge, including mid-RUN or in DONE, forces:
  - IDLE, counter 0, borrow FF 0;
  - `busy` = 0, `done` = 0, `diff` = 0, `bout` = 0, `ovf` = 0.
  - The interrupted operation is discarded and no `done` pulse is produced.
  - `rst_n` takes priority over `start`.

## Timing
- **Reset values:** all outputs 0, state IDLE.
- **Accept edge:** call the edge that samples `start` = 1 in IDLE "edge 0".
- **`busy`:** high for exactly WIDTH cycles, from after edge 0 until edge WIDTH.
- **`done` and results:** `done` is high for the single cycle between edge WIDTH and edge WIDTH+1. `diff`/`bout`/`ovf` are valid from edge WIDTH onward.
- **Latency:** WIDTH cycles from the accepting edge to `done`.
- **Throughput:** with `start` held high, operations are accepted at edge 0, WIDTH+2, 2(WIDTH+2), …; the period is WIDTH+2 cycles.
- **Mutual exclusion:** `busy` and `done` are never high together.
- **Outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
WIDTH = 8 throughout.
- **Basic:** a=0x05, b=0x03, bin=0 → diff=0x02, bout=0, ovf=0. `busy` high 8 cycles; `done` pulses once, exactly 8 cycles after edge 0.
- **Borrow wrap:** a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0.
- **Signed overflow:**
  - a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0xFF, bin=0 → diff=0x80, bout=1, ovf=1.
- **Borrow-in:** a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0, ovf=0. Also a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- **Robustness:**
  - In RUN, pulse `start` and change a/b to 0xAA/0x55 → the in-flight result is unchanged and no extra `done` occurs.
  - Drive `rst_n` low at the 4th RUN cycle → next cycle all outputs are 0, state is IDLE, no `done`.
- **Back-to-back:** hold `start` high with operand pairs (0x05,0x03) then (0x00,0x01) → `done` pulses 10 cycles apart. `diff` reads 0x02, then 0xFF, and holds between pulses.
